// File: rtl/shift_reg_pkg.sv
// Shared defaults for the N-bit shift register family.
// SHIFT_REG_GEN_STRUCT_EN picks the default build: per-bit sr_dff generate chain when defined, vector procedural block otherwise.
package shift_reg_pkg;

   localparam int          SR_DEFAULT_N         = 8;
   localparam logic [63:0] SR_DEFAULT_RESET_VAL = '0;

`ifdef SHIFT_REG_GEN_STRUCT_EN
   localparam bit SR_DEFAULT_GEN_STRUCT = 1'b1;
`else
   localparam bit SR_DEFAULT_GEN_STRUCT = 1'b0;
`endif

endpackage

// File: rtl/n_bit_shift_register_w_always_sr_dff.sv
// Single-bit D flop with synchronous active-low reset to a per-stage value.
// Building block of the generate-style shift register.
module sr_dff (
   input  logic d,
   input  logic rst,
   input  logic clk,
   input  logic rstval,
   output logic q
);

   always_ff @(posedge clk) begin
      if (!rst) begin
         q <= rstval;
      end else begin
         q <= d;
      end
   end

endmodule

// File: rtl/n_bit_shift_register_w_always_variants.sv
// Fixed-style wrappers so both implementations can be instantiated side by side.
// nBitShiftRegisterwGen forces the sr_dff chain, nBitShiftRegisterwAlways the vector block.
module nBitShiftRegisterwGen
   import shift_reg_pkg::*;
#(
   parameter int           N         = SR_DEFAULT_N,
   parameter logic [0:N-1] RESET_VAL = SR_DEFAULT_RESET_VAL[N-1:0]
) (
   input  logic         sln,
   input  logic         rst,
   input  logic         clk,
   output logic [0:N-1] q
);

   n_bit_shift_register_w_always #(
      .N          (N),
      .RESET_VAL  (RESET_VAL),
      .GEN_STRUCT (1'b1)
   ) u_core (
      .sln (sln),
      .rst (rst),
      .clk (clk),
      .q   (q)
   );

endmodule

module nBitShiftRegisterwAlways
   import shift_reg_pkg::*;
#(
   parameter int           N         = SR_DEFAULT_N,
   parameter logic [0:N-1] RESET_VAL = SR_DEFAULT_RESET_VAL[N-1:0]
) (
   input  logic         sln,
   input  logic         rst,
   input  logic         clk,
   output logic [0:N-1] q
);

   n_bit_shift_register_w_always #(
      .N          (N),
      .RESET_VAL  (RESET_VAL),
      .GEN_STRUCT (1'b0)
   ) u_core (
      .sln (sln),
      .rst (rst),
      .clk (clk),
      .q   (q)
   );

endmodule

// File: rtl/n_bit_shift_register_w_always.sv
// N-bit serial-in/parallel-out shift register; q[0] is the entry stage.
// SHIFT_REG_GEN_STRUCT_EN (via shift_reg_pkg) sets the default of GEN_STRUCT; both styles are cycle-identical.
module n_bit_shift_register_w_always
   import shift_reg_pkg::*;
#(
   parameter int           N          = SR_DEFAULT_N,
   parameter logic [0:N-1] RESET_VAL  = SR_DEFAULT_RESET_VAL[N-1:0],
   parameter bit           GEN_STRUCT = SR_DEFAULT_GEN_STRUCT
) (
   input  logic         sln,
   input  logic         rst,
   input  logic         clk,
   output logic [0:N-1] q
);

   if (GEN_STRUCT) begin : g_struct
      // Each stage is its own flop; stage 0 takes sln, the rest take their predecessor.
      for (genvar i = 0; i < N; i++) begin : g_stage
         logic d;
         if (i == 0) begin : g_head
            assign d = sln;
         end else begin : g_tail
            assign d = q[i-1];
         end
         sr_dff u_dff (
            .d      (d),
            .rst    (rst),
            .clk    (clk),
            .rstval (RESET_VAL[i]),
            .q      (q[i])
         );
      end
   end else begin : g_always
      always_ff @(posedge clk) begin
         if (!rst) begin
            q <= RESET_VAL;
         end else begin
            q[0] <= sln;
            for (int i = 1; i < N; i++) begin
               q[i] <= q[i-1];
            end
         end
      end
   end

endmodule

// File: tb/tb_n_bit_shift_register_w_always.sv
// Bench for n_bit_shift_register_w_always: queue-based history model, directed vectors,
// and a random Gen-vs-Always cross-check at N=1, 8 and 64.
module tb_n_bit_shift_register_w_always;

   localparam int N = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic         sln;
   logic [0:N-1] q;

   logic         r_rst;
   logic         r_sln;
   logic [0:0]   q1_gen,  q1_alw;
   logic [0:7]   q8_gen,  q8_alw;
   logic [0:63]  q64_gen, q64_alw;

   int checks = 0;
   int errors = 0;

   bit reset_seen  = 1'b0;
   bit rand_active = 1'b0;
   logic hist[$];

   always #200 clk = ~clk;

   n_bit_shift_register_w_always #(.N(N)) dut (
      .sln (sln),
      .rst (rst),
      .clk (clk),
      .q   (q)
   );

   nBitShiftRegisterwGen    #(.N(1))  u_gen1  (.sln(r_sln), .rst(r_rst), .clk(clk), .q(q1_gen));
   nBitShiftRegisterwAlways #(.N(1))  u_alw1  (.sln(r_sln), .rst(r_rst), .clk(clk), .q(q1_alw));
   nBitShiftRegisterwGen    #(.N(8))  u_gen8  (.sln(r_sln), .rst(r_rst), .clk(clk), .q(q8_gen));
   nBitShiftRegisterwAlways #(.N(8))  u_alw8  (.sln(r_sln), .rst(r_rst), .clk(clk), .q(q8_alw));
   nBitShiftRegisterwGen    #(.N(64)) u_gen64 (.sln(r_sln), .rst(r_rst), .clk(clk), .q(q64_gen));
   nBitShiftRegisterwAlways #(.N(64)) u_alw64 (.sln(r_sln), .rst(r_rst), .clk(clk), .q(q64_alw));

   // The model remembers the bits accepted since the last reset, newest first.
   always @(posedge clk) begin
      if (rst === 1'b0) begin
         hist.delete();
         reset_seen = 1'b1;
      end else if (rst === 1'b1) begin
         hist.push_front(sln);
         if (hist.size() > N) void'(hist.pop_back());
      end
   end

   function automatic logic [0:N-1] model_q();
      logic [0:N-1] m;
      for (int j = 0; j < N; j++) begin
         m[j] = (j < hist.size()) ? hist[j] : 1'b0;
      end
      return m;
   endfunction

   always @(negedge clk) begin
      if (reset_seen) begin
         checks++;
         if (q !== model_q()) begin
            errors++;
            $display("[TB] FAIL model_track: q=%b expected %b at %0t", q, model_q(), $time);
         end
      end
   end

   always @(negedge clk) begin
      if (rand_active) begin
         checks += 3;
         if (q1_gen !== q1_alw) begin
            errors++;
            $display("[TB] FAIL gen_vs_always_n1: gen=%b always=%b at %0t", q1_gen, q1_alw, $time);
         end
         if (q8_gen !== q8_alw) begin
            errors++;
            $display("[TB] FAIL gen_vs_always_n8: gen=%b always=%b at %0t", q8_gen, q8_alw, $time);
         end
         if (q64_gen !== q64_alw) begin
            errors++;
            $display("[TB] FAIL gen_vs_always_n64: gen=%h always=%h at %0t", q64_gen, q64_alw, $time);
         end
      end
   end

   task automatic apply_stimulus(input logic r, input logic s);
      rst = r;
      sln = s;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic check_output(input string name, input logic [0:N-1] expected);
      checks++;
      if (q !== expected) begin
         errors++;
         $display("[TB] FAIL %s: q=%b expected %b", name, q, expected);
      end
   endtask

   initial begin
      logic [0:7] seq;
      rst   = 1'b0;
      sln   = 1'b1;
      r_rst = 1'b1;
      r_sln = 1'b0;
      @(negedge clk);

      $display("[TB] reset with sln high");
      apply_stimulus(1'b0, 1'b1);
      check_output("reset_clears", 8'b0000_0000);

      $display("[TB] fill with ones");
      for (int k = 1; k <= 8; k++) begin
         apply_stimulus(1'b1, 1'b1);
         if (k == 4) check_output("fill_half", 8'b1111_0000);
      end
      check_output("fill_full", 8'b1111_1111);

      $display("[TB] reset level without an edge");
      #100 rst = 1'b0;
      #50 check_output("async_hold", 8'b1111_1111);
      rst = 1'b1;
      @(negedge clk);
      check_output("after_hold_shift", 8'b1111_1111);

      $display("[TB] mid-stream reset");
      apply_stimulus(1'b0, 1'b1);
      check_output("midstream_reset", 8'b0000_0000);
      apply_stimulus(1'b1, 1'b1);
      check_output("resume_after_reset", 8'b1000_0000);

      $display("[TB] serial pattern");
      apply_stimulus(1'b0, 1'b0);
      seq = 8'b1011_0010;
      for (int k = 0; k < 8; k++) apply_stimulus(1'b1, seq[k]);
      check_output("pattern_10110010", 8'b0100_1101);

      $display("[TB] sln toggling off the clock grid");
      rst = 1'b1;
      sln = 1'b0;
      #25;
      for (int k = 0; k < 16; k++) begin
         sln = ~sln;
         #250;
      end
      @(negedge clk);

      $display("[TB] random Gen vs Always comparison");
      for (int c = 0; c < 1000; c++) begin
         r_rst = (c == 0) ? 1'b0 : ($urandom_range(0, 9) != 0);
         r_sln = 1'($urandom_range(0, 1));
         rst   = r_rst;
         sln   = r_sln;
         @(posedge clk);
         @(negedge clk);
         if (c == 0) rand_active = 1'b1;
      end
      rand_active = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/n_bit_shift_register_w_always.md
N_BIT_SHIFT_REGISTER_W_ALWAYS -- requirements
Module: n_bit_shift_register_w_always

Interface
REQ-001 Parameter N, default 8, meaning register length in bits; legal range 1..64.
REQ-002 Parameter RESET_VAL, width N, default all-zeros, meaning value loaded into q during reset.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset; synchronous and active-low (rst=0 resets).
REQ-005 sln  input  1  serial data in.
REQ-006 q  output  N, declared [0:N-1]  parallel register contents; q[0] is the entry stage.
REQ-007 Port order SHALL be (sln, rst, clk, q) so positional instantiation is valid.

Function
REQ-008 On a rising clk edge with rst=1: q[0] <= sln and q[i] <= q[i-1] for i=1..N-1; the old q[N-1] is discarded.
REQ-009 On a rising clk edge with rst=0: q <= RESET_VAL, and sln is ignored on that edge.
REQ-010 Between rising edges q SHALL hold its value; sln changes between edges have no effect.
REQ-011 Latency: a bit sampled on sln at edge k appears on q[0] after edge k and on q[j] after edge k+j.
REQ-012 N=1 SHALL degenerate to a single D flip-flop (q[0] <= sln).
REQ-013 q SHALL be driven directly by flops; no combinational path from sln or rst to q.

Reset
REQ-014 Reset is synchronous only; asserting rst without a clock edge SHALL NOT change q.
REQ-015 Reset asserted mid-stream SHALL discard all in-flight bits at the next edge; shifting resumes on the first edge with rst=1.
REQ-016 Before the first reset edge q is undefined; the bench SHALL NOT check q until one reset edge has occurred.

Configuration
REQ-017 Macro SHIFT_REG_GEN_STRUCT_EN selects the implementation style with identical cycle behaviour.
REQ-018 When SHIFT_REG_GEN_STRUCT_EN is defined, the register SHALL be built as a generate loop of N sr_dff instances; this build is the nBitShiftRegisterwGen variant.
REQ-019 When SHIFT_REG_GEN_STRUCT_EN is undefined, the register SHALL be a single clocked procedural block over the whole vector; this build is the nBitShiftRegisterwAlways variant.
REQ-020 Both builds SHALL produce bit-identical q for identical stimulus on every cycle.

Structure
REQ-021 Package shift_reg_pkg SHALL hold SR_DEFAULT_N (8) and SR_DEFAULT_RESET_VAL (0); the module parameter defaults SHALL reference it.
REQ-022 Sub-module sr_dff: ports (d, rst, clk, rstval, q), 1-bit D flop with synchronous active-low reset to rstval; used only by the generate build.
REQ-023 Wrapper module names nBitShiftRegisterwGen and nBitShiftRegisterwAlways SHALL each instantiate n_bit_shift_register_w_always with the corresponding style fixed, for side-by-side comparison.

Verification
REQ-024 rst=0 for 1 edge, sln=1 -> q=8'b0000_0000 after that edge, in both builds.
REQ-025 After reset, rst=1, sln=1 held 8 edges -> q[0..7] fill one bit per edge, q=8'b1111_1111 after the 8th edge.
REQ-026 After reset, sln sequence 1,0,1,1,0,0,1,0 on successive edges -> q[0:7]=0,1,0,0,1,1,0,1 after the 8th edge.
REQ-027 sln toggled every 250 ns against a 400 ns clock -> each q[0] update equals sln sampled at that rising edge; q[j] equals q[j-1] one edge earlier.
REQ-028 q=8'hFF, rst=0 for one edge mid-stream -> q=8'h00 next edge; rst=1 with sln=1 -> q=8'b1000_0000 on the following edge.
REQ-029 Gen and Always wrappers driven in parallel with random sln/rst for 1000 cycles -> q_gen == q_always on every edge, for N=1, 8 and 64.
